// File: rtl/ram_responder.sv
// ram_responder: RAM side of the MFA/MFC handshake.
// Big-endian byte/half/word/doubleword access with programmable latency.
module ram_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_BYTES   = 512
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ramMFA,
  input  logic                         ramRW,
  input  logic [1:0]                   ramDataSize,
  input  logic [$clog2(MEM_BYTES)-1:0] ramAddress,
  input  logic [31:0]                  dataIn,
  output logic [31:0]                  dataOut,
  output logic                         ramMFC,
  output logic                         ramAlignErr
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_BEAT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_REL  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          beat2_q, beat2_d;
  logic          mfc_q, mfc_d;
  logic          err_q, err_d;
  logic [31:0]   dout_q, dout_d;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] idx [4];
  logic [7:0]    rbyte [4];
  logic [31:0]   rdata;
  logic          misalign;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [7:0]    wr_byte [4];

  assign dataOut     = dout_q;
  assign ramMFC      = mfc_q;
  assign ramAlignErr = err_q;

  // Four consecutive byte lanes from the latched address, wrapping.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      idx[i]   = addr_q + AW'(i);
      rbyte[i] = mem[idx[i]];
    end
  end

  // Alignment rule for the latched size.
  always_comb begin
    misalign = 1'b0;
    case (size_q)
      2'b01:   misalign = addr_q[0];
      2'b10,
      2'b11:   misalign = |addr_q[1:0];
      default: misalign = 1'b0;
    endcase
  end

  // Right-justified read data and big-endian write lanes.
  always_comb begin
    rdata = '0;
    wr_be = '0;
    for (int i = 0; i < 4; i++) wr_byte[i] = 8'h00;
    case (size_q)
      2'b00: begin
        rdata      = {24'h0, rbyte[0]};
        wr_be      = 4'b0001;
        wr_byte[0] = dataIn[7:0];
      end
      2'b01: begin
        rdata      = {16'h0, rbyte[0], rbyte[1]};
        wr_be      = 4'b0011;
        wr_byte[0] = dataIn[15:8];
        wr_byte[1] = dataIn[7:0];
      end
      default: begin
        rdata      = {rbyte[0], rbyte[1], rbyte[2], rbyte[3]};
        wr_be      = 4'b1111;
        wr_byte[0] = dataIn[31:24];
        wr_byte[1] = dataIn[23:16];
        wr_byte[2] = dataIn[15:8];
        wr_byte[3] = dataIn[7:0];
      end
    endcase
  end

  // Handshake sequencing: latch, wait, beat, optional second beat, release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    size_d  = size_q;
    addr_d  = addr_q;
    beat2_d = beat2_q;
    mfc_d   = 1'b0;
    err_d   = 1'b0;
    dout_d  = dout_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ramMFA) begin
          rw_d    = ramRW;
          size_d  = ramDataSize;
          addr_d  = ramAddress;
          cnt_d   = '0;
          beat2_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST) begin
          mfc_d   = 1'b1;
          err_d   = misalign;
          state_d = S_BEAT;
          if (rw_q) dout_d = misalign ? 32'h0 : rdata;
          else      wr_en  = !misalign;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_BEAT: begin
        if (size_q == 2'b11 && !beat2_q && !misalign)
          state_d = S_GAP;
        else
          state_d = S_REL;
      end
      S_GAP: begin
        addr_d  = addr_q + AW'(4);
        cnt_d   = '0;
        beat2_d = 1'b1;
        state_d = S_WAIT;
      end
      S_REL: begin
        if (!ramMFA) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      beat2_q <= 1'b0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      beat2_q <= beat2_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Byte array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[idx[i]] <= wr_byte[i];
    end
  end

endmodule
